// File: rtl/bus_if_types_pkg.sv
// Shared transaction types for master_bus_if responders, plus byte-lane helpers
// reused by every slave that steers sub-word accesses.
package bus_if_types_pkg;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } ttype_e;

    // Encoding follows RISC-V funct3[1:0]; 2'b11 is not a legal size.
    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } tsize_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StWait = 2'b01,
        StResp = 2'b10
    } slave_state_e;

    function automatic logic [3:0] lane_be(tsize_e size, logic [1:0] off);
        logic [3:0] be;
        case (size)
            BYTE:    be = 4'b0001 << off;
            HALF:    be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Unknown sizes collapse onto WORD so the datapath only sees three cases.
    function automatic tsize_e norm_size(tsize_e size);
        tsize_e s;
        case (size)
            BYTE:    s = BYTE;
            HALF:    s = HALF;
            default: s = WORD;
        endcase
        return s;
    endfunction

    function automatic logic [1:0] align_off(tsize_e size, logic [1:0] off);
        logic [1:0] o;
        case (size)
            BYTE:    o = off;
            HALF:    o = {off[1], 1'b0};
            default: o = 2'b00;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/master_bus_if.sv
// Core master bus: breq/bstart request held until a one-cycle bdone completion.
interface master_bus_if;
    import bus_if_types_pkg::*;

    logic        breq;
    logic        bstart;
    ttype_e      ttype;
    tsize_e      tsize;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        bdone;

    modport master (
        output breq,
        output bstart,
        output ttype,
        output tsize,
        output addr,
        output wdata,
        input  rdata,
        input  bdone
    );

    modport slave (
        input  breq,
        input  bstart,
        input  ttype,
        input  tsize,
        input  addr,
        input  wdata,
        output rdata,
        output bdone
    );

endinterface

// File: rtl/sram_be.sv
// Synchronous single-port 32-bit RAM with per-byte write enables and a registered,
// read-first output. Contents are never reset.
module sram_be #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter string       INIT_FILE   = ""
) (
    input  logic                           clk,
    input  logic                           en,
    input  logic [3:0]                     we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/bus_sram_slave.sv
// SRAM responder for master_bus_if with lane steering and WAIT_STATES wait cycles.
// Define BUS_SRAM_ERR_EN to add the err port and fault misaligned/out-of-range accesses.
module bus_sram_slave
    import bus_if_types_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    master_bus_if.slave bus
`ifdef BUS_SRAM_ERR_EN
    ,
    output logic        err
`endif
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WaitLoad = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    slave_state_e state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  wdata_q, wdata_d;
    ttype_e       ttype_q, ttype_d;
    tsize_e       tsize_q, tsize_d;

    logic          accept;
    logic          resp;
    logic          fault;
    logic [1:0]    off;
    logic [AW-1:0] req_idx;
    logic [AW-1:0] hold_idx;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_idx;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic [31:0]   lane_rdata;

    assign accept   = (state_q == StIdle) && bus.breq && bus.bstart;
    assign req_idx  = AW'((bus.addr - BASE_ADDR) >> 2);
    assign hold_idx = AW'((addr_q - BASE_ADDR) >> 2);

`ifdef BUS_SRAM_ERR_EN
    logic misaligned;
    logic out_of_range;
    assign misaligned   = (tsize_q == HALF && addr_q[0]) ||
                          (tsize_q == WORD && addr_q[1:0] != 2'b00);
    assign out_of_range = ((addr_q - BASE_ADDR) >> (AW + 2)) != 32'd0;
    assign fault        = misaligned || out_of_range;
    assign off          = addr_q[1:0];
`else
    // Without fault reporting, sub-word offsets snap down to natural alignment.
    assign fault = 1'b0;
    assign off   = align_off(tsize_q, addr_q[1:0]);
`endif

    assign mem_wdata  = wdata_q << {off, 3'b000};
    assign lane_rdata = mem_rdata >> {off, 3'b000};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ttype_d = ttype_q;
        tsize_d = tsize_q;
        mem_en  = 1'b0;
        mem_we  = 4'b0000;
        mem_idx = hold_idx;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    ttype_d = bus.ttype;
                    tsize_d = norm_size(bus.tsize);
                    // The read is issued on accept so data is ready by RESP.
                    mem_en  = 1'b1;
                    mem_idx = req_idx;
                    if (WAIT_STATES > 0) begin
                        state_d = StWait;
                        cnt_d   = WaitLoad;
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
                if (!rst && ttype_q == WRITE && !fault) begin
                    mem_en = 1'b1;
                    mem_we = lane_be(tsize_q, off);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            ttype_q <= READ;
            tsize_q <= WORD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ttype_q <= ttype_d;
            tsize_q <= tsize_d;
        end
    end

    // Reset suppresses the completion even if it lands on the RESP cycle.
    always_comb begin
        resp      = (state_q == StResp) && !rst;
        bus.bdone = resp;
        bus.rdata = 32'h0;
        if (resp && ttype_q == READ && !fault) begin
            case (tsize_q)
                BYTE:    bus.rdata = {24'h0, lane_rdata[7:0]};
                HALF:    bus.rdata = {16'h0, lane_rdata[15:0]};
                default: bus.rdata = lane_rdata;
            endcase
        end
    end

`ifdef BUS_SRAM_ERR_EN
    assign err = resp && fault;
`endif

    sram_be #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .INIT_FILE   (INIT_FILE)
    ) u_sram (
        .clk   (clk),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (mem_idx),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_bus_sram_slave.sv
// Bench for bus_sram_slave: a zero-wait and a three-wait instance checked by a
// completion scoreboard fed from a vector table and a few hand-written sequences.
module tb_bus_sram_slave;
    import bus_if_types_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    master_bus_if b0 ();
    master_bus_if b3 ();
`ifdef BUS_SRAM_ERR_EN
    logic err0;
    logic err3;
`endif

    bus_sram_slave #(.WAIT_STATES(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
`ifdef BUS_SRAM_ERR_EN
        ,
        .err (err0)
`endif
    );

    bus_sram_slave #(.WAIT_STATES(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (b3)
`ifdef BUS_SRAM_ERR_EN
        ,
        .err (err3)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        chk;
        logic        err;
        int unsigned acc_cyc;
    } exp_t;

    typedef struct {
        ttype_e      t;
        tsize_e      s;
        logic [31:0] a;
        logic [31:0] w;
        logic [31:0] exp;
    } vec_t;

    exp_t        q0[$];
    exp_t        q3[$];
    int unsigned cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;
    int          done_cnt0 = 0;
    int          done_cnt3 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic mon_port(input int d);
        exp_t        x;
        logic        done;
        logic [31:0] rd;
        int          qn;
`ifdef BUS_SRAM_ERR_EN
        logic        e;
        e = (d == 0) ? err0 : err3;
`endif
        done = (d == 0) ? b0.bdone : b3.bdone;
        rd   = (d == 0) ? b0.rdata : b3.rdata;
        qn   = (d == 0) ? q0.size() : q3.size();
        if (done === 1'b1) begin
            if (d == 0) done_cnt0++; else done_cnt3++;
            if (qn == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL dut%0d_unexpected_bdone: got bdone=1, expected none", d);
            end else begin
                if (d == 0) x = q0.pop_front(); else x = q3.pop_front();
                check($sformatf("dut%0d_latency@%h", d, x.addr), cyc - x.acc_cyc,
                      (d == 0) ? 32'd1 : 32'd4);
                if (x.chk) check($sformatf("dut%0d_rdata@%h", d, x.addr), rd, x.rdata);
`ifdef BUS_SRAM_ERR_EN
                check($sformatf("dut%0d_err@%h", d, x.addr), {31'h0, e}, {31'h0, x.err});
`endif
            end
        end else begin
            check($sformatf("dut%0d_rdata_idle", d), rd, 32'h0);
`ifdef BUS_SRAM_ERR_EN
            check($sformatf("dut%0d_err_idle", d), {31'h0, e}, 32'h0);
`endif
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_port(0);
            mon_port(3);
        end
    end

    task automatic drive(input int d, input logic rq, input logic st, input ttype_e t,
                         input tsize_e s, input logic [31:0] a, input logic [31:0] w);
        if (d == 0) begin
            b0.breq = rq; b0.bstart = st; b0.ttype = t; b0.tsize = s; b0.addr = a; b0.wdata = w;
        end else begin
            b3.breq = rq; b3.bstart = st; b3.ttype = t; b3.tsize = s; b3.addr = a; b3.wdata = w;
        end
    endtask

    // Called just after a rising edge with the slave idle; returns just after the
    // edge that ends the bdone cycle.
    task automatic txn(input int d, input ttype_e t, input tsize_e s, input logic [31:0] a,
                       input logic [31:0] w, input logic [31:0] exp, input logic e,
                       input logic hold);
        exp_t x;
        logic seen;
        drive(d, 1'b1, 1'b1, t, s, a, w);
        x.addr    = a;
        x.rdata   = exp;
        x.chk     = (t == READ);
        x.err     = e;
        x.acc_cyc = cyc;
        if (d == 0) q0.push_back(x); else q3.push_back(x);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = (d == 0) ? b0.bdone : b3.bdone;
        end
        if (seen !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL dut%0d_bdone_timeout@%h: got no bdone, expected one", d, a);
        end
        @(posedge clk);
        #1;
        if (!hold) drive(d, 1'b0, 1'b0, READ, WORD, 32'h0, 32'h0);
    endtask

    vec_t        tbl[16];
    int          base;
    int unsigned c1, c2, c3;

    initial begin
        tbl[0]  = '{WRITE, WORD, 32'h10, 32'hDEADBEEF, 32'h0};
        tbl[1]  = '{READ,  WORD, 32'h10, 32'h0,       32'hDEADBEEF};
        tbl[2]  = '{WRITE, WORD, 32'h10, 32'h11223344, 32'h0};
        tbl[3]  = '{WRITE, BYTE, 32'h13, 32'h000000A5, 32'h0};
        tbl[4]  = '{READ,  BYTE, 32'h13, 32'h0,       32'h000000A5};
        tbl[5]  = '{READ,  WORD, 32'h10, 32'h0,       32'hA5223344};
        tbl[6]  = '{WRITE, WORD, 32'h14, 32'hCAFEF00D, 32'h0};
        tbl[7]  = '{WRITE, HALF, 32'h16, 32'h1234BEEF, 32'h0};
        tbl[8]  = '{READ,  WORD, 32'h14, 32'h0,       32'hBEEFF00D};
        tbl[9]  = '{READ,  BYTE, 32'h11, 32'h0,       32'h00000033};
        tbl[10] = '{READ,  HALF, 32'h12, 32'h0,       32'h0000A522};
        tbl[11] = '{READ,  tsize_e'(2'b11), 32'h10, 32'h0, 32'hA5223344};
        tbl[12] = '{WRITE, BYTE, 32'h10, 32'hFFFFFF77, 32'h0};
        tbl[13] = '{READ,  WORD, 32'h10, 32'h0,       32'hA5223377};
        tbl[14] = '{READ,  HALF, 32'h16, 32'h0,       32'h0000BEEF};
        tbl[15] = '{READ,  BYTE, 32'h14, 32'h0,       32'h0000000D};

        rst = 1'b1;
        drive(0, 1'b0, 1'b0, READ, WORD, 32'h0, 32'h0);
        drive(3, 1'b0, 1'b0, READ, WORD, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_bdone0", {31'h0, b0.bdone}, 32'h0);
        check("reset_rdata0", b0.rdata, 32'h0);
        check("reset_bdone3", {31'h0, b3.bdone}, 32'h0);
        check("reset_rdata3", b3.rdata, 32'h0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            txn(0, tbl[i].t, tbl[i].s, tbl[i].a, tbl[i].w, tbl[i].exp, 1'b0, 1'b0);
        end

        // Three wait states: latency 4, halfword returned unsigned.
        txn(3, WRITE, WORD, 32'h10, 32'h80017777, 32'h0, 1'b0, 1'b0);
        txn(3, READ,  HALF, 32'h12, 32'h0, 32'h00008001, 1'b0, 1'b0);
        txn(3, READ,  BYTE, 32'h13, 32'h0, 32'h00000080, 1'b0, 1'b0);

        // bstart held across three back-to-back reads.
        txn(0, WRITE, WORD, 32'h0, 32'h0A0B0C0D, 32'h0, 1'b0, 1'b0);
        txn(0, WRITE, WORD, 32'h4, 32'h11112222, 32'h0, 1'b0, 1'b0);
        txn(0, WRITE, WORD, 32'h8, 32'h33334444, 32'h0, 1'b0, 1'b0);
        txn(0, READ, WORD, 32'h0, 32'h0, 32'h0A0B0C0D, 1'b0, 1'b1);
        c1 = cyc;
        txn(0, READ, WORD, 32'h4, 32'h0, 32'h11112222, 1'b0, 1'b1);
        c2 = cyc;
        txn(0, READ, WORD, 32'h8, 32'h0, 32'h33334444, 1'b0, 1'b0);
        c3 = cyc;
        check("b2b_spacing_1", c2 - c1, 32'd2);
        check("b2b_spacing_2", c3 - c2, 32'd2);

        // breq low with bstart high must not start anything.
        base = done_cnt0;
        drive(0, 1'b0, 1'b1, READ, WORD, 32'h10, 32'h0);
        repeat (5) @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, READ, WORD, 32'h0, 32'h0);
        check("no_accept_breq0", done_cnt0 - base, 32'd0);

        // Reset during WAIT drops the write and its completion.
        txn(3, WRITE, WORD, 32'h20, 32'h5555AAAA, 32'h0, 1'b0, 1'b0);
        base = done_cnt3;
        drive(3, 1'b1, 1'b1, WRITE, WORD, 32'h20, 32'hFFFFFFFF);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(3, 1'b0, 1'b0, READ, WORD, 32'h0, 32'h0);
        repeat (6) @(posedge clk);
        #1;
        check("abort_wait_no_bdone", done_cnt3 - base, 32'd0);
        txn(3, READ, WORD, 32'h20, 32'h0, 32'h5555AAAA, 1'b0, 1'b0);

        // Reset landing on the RESP cycle also drops the write and bdone.
        txn(0, WRITE, WORD, 32'h24, 32'h13579BDF, 32'h0, 1'b0, 1'b0);
        base = done_cnt0;
        drive(0, 1'b1, 1'b1, WRITE, WORD, 32'h24, 32'hFFFFFFFF);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, READ, WORD, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_resp_no_bdone", done_cnt0 - base, 32'd0);
        txn(0, READ, WORD, 32'h24, 32'h0, 32'h13579BDF, 1'b0, 1'b0);

        txn(0, WRITE, WORD, 32'h20, 32'h01234567, 32'h0, 1'b0, 1'b0);
`ifdef BUS_SRAM_ERR_EN
        txn(0, WRITE, WORD, 32'h22, 32'hCAFE1234, 32'h0, 1'b1, 1'b0);
        txn(0, READ,  WORD, 32'h20, 32'h0, 32'h01234567, 1'b0, 1'b0);
        txn(0, READ,  HALF, 32'h23, 32'h0, 32'h0, 1'b1, 1'b0);
        txn(0, READ,  WORD, 32'h1010, 32'h0, 32'h0, 1'b1, 1'b0);
        txn(0, READ,  HALF, 32'h22, 32'h0, 32'h00000123, 1'b0, 1'b0);
`else
        txn(0, WRITE, WORD, 32'h22, 32'hCAFE1234, 32'h0, 1'b0, 1'b0);
        txn(0, READ,  WORD, 32'h20, 32'h0, 32'hCAFE1234, 1'b0, 1'b0);
        txn(0, READ,  HALF, 32'h23, 32'h0, 32'h0000CAFE, 1'b0, 1'b0);
        txn(0, READ,  WORD, 32'h1010, 32'h0, 32'hA5223377, 1'b0, 1'b0);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", q0.size() + q3.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
